// File: rtl/mips_pkg.sv
// Shared MIPS-Lite pipeline types: control bundle, instruction classes,
// MEM/WB pipeline register layout and write-back FSM states.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int REGADDR_W = 5;

    typedef enum logic [1:0] {
        ARITH,
        LOGICAL,
        MEMACC,
        CONTROL
    } InstrClass;

    typedef struct packed {
        logic      regWrite;
        logic      memToReg;
        logic      halt;
        InstrClass iClass;
    } Control;

    typedef struct packed {
        logic                 valid;
        logic                 regWrite;
        logic                 memToReg;
        logic                 halt;
        InstrClass            iClass;
        logic [REGADDR_W-1:0] destReg;
        logic [DATA_W-1:0]    memData;
        logic [DATA_W-1:0]    aluData;
    } MemWbReg;

    typedef enum logic {
        RUN,
        HALTED
    } WbState;

endpackage

// File: rtl/wb_stage_retire_counters.sv
// Saturating per-class retirement counters fed by the write-back stage.
module retire_counters
    import mips_pkg::*;
#(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            retire,
    input  InstrClass       iClass,
    output logic [CNTW-1:0] totalCount,
    output logic [CNTW-1:0] arithCount,
    output logic [CNTW-1:0] logicCount,
    output logic [CNTW-1:0] memCount,
    output logic [CNTW-1:0] ctrlCount
);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            totalCount <= '0;
            arithCount <= '0;
            logicCount <= '0;
            memCount   <= '0;
            ctrlCount  <= '0;
        end else if (retire) begin
            totalCount <= sat_inc(totalCount);
            case (iClass)
                ARITH:   arithCount <= sat_inc(arithCount);
                LOGICAL: logicCount <= sat_inc(logicCount);
                MEMACC:  memCount   <= sat_inc(memCount);
                CONTROL: ctrlCount  <= sat_inc(ctrlCount);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS-Lite write-back stage: MEM/WB register, write-back mux, retirement
// counters and the HALT state machine.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA    = DATA_W,
    parameter int REGADDR = REGADDR_W,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               validIn,
    input  Control             cntrl,
    input  logic [REGADDR-1:0] destReg,
    input  logic [DATA-1:0]    memDataOut,
    input  logic [DATA-1:0]    writeBackData,
    output logic               rfWriteEnable,
    output logic [REGADDR-1:0] rfWriteAddr,
    output logic [DATA-1:0]    rfWriteData,
    output logic               retire,
    output logic               halted,
    output logic [CNTW-1:0]    totalCount,
    output logic [CNTW-1:0]    arithCount,
    output logic [CNTW-1:0]    logicCount,
    output logic [CNTW-1:0]    memCount,
    output logic [CNTW-1:0]    ctrlCount
);

    MemWbReg wb;
    WbState  state;
    logic    gate;

    // A HALT sitting in the register closes the gate one edge before the
    // FSM reaches HALTED, so nothing behind it is ever captured.
    assign gate = (state == RUN) && !(wb.valid && wb.halt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb     <= '0;
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            if (gate) begin
                wb <= '{valid:    validIn,
                        regWrite: cntrl.regWrite,
                        memToReg: cntrl.memToReg,
                        halt:     cntrl.halt,
                        iClass:   cntrl.iClass,
                        destReg:  destReg,
                        memData:  memDataOut,
                        aluData:  writeBackData};
            end else begin
                wb <= '0;
            end

            case (state)
                RUN: begin
                    if (wb.valid && wb.halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

    assign rfWriteData   = wb.memToReg ? wb.memData : wb.aluData;
    assign rfWriteAddr   = wb.destReg;
    assign rfWriteEnable = wb.valid && wb.regWrite && (wb.destReg != '0);
    assign retire        = wb.valid;

    retire_counters #(
        .CNTW(CNTW)
    ) u_counters (
        .clk       (clk),
        .reset     (reset),
        .retire    (retire),
        .iClass    (wb.iClass),
        .totalCount(totalCount),
        .arithCount(arithCount),
        .logicCount(logicCount),
        .memCount  (memCount),
        .ctrlCount (ctrlCount)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, randomized stream against a
// behavioural model, reset/HALT/saturation sequences.
module tb_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        validIn;
    Control      cntrl;
    logic [4:0]  destReg;
    logic [31:0] memDataOut, writeBackData;
    logic        rfWriteEnable, retire, halted;
    logic [4:0]  rfWriteAddr;
    logic [31:0] rfWriteData;
    logic [31:0] totalCount, arithCount, logicCount, memCount, ctrlCount;

    logic        s_validIn;
    Control      s_cntrl;
    logic        s_we, s_retire, s_halted;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_total, s_arith, s_logic, s_mem, s_ctrl;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .validIn(validIn), .cntrl(cntrl),
        .destReg(destReg), .memDataOut(memDataOut), .writeBackData(writeBackData),
        .rfWriteEnable(rfWriteEnable), .rfWriteAddr(rfWriteAddr),
        .rfWriteData(rfWriteData), .retire(retire), .halted(halted),
        .totalCount(totalCount), .arithCount(arithCount), .logicCount(logicCount),
        .memCount(memCount), .ctrlCount(ctrlCount)
    );

    wb_stage #(.CNTW(4)) dut_sat (
        .clk(clk), .reset(reset), .validIn(s_validIn), .cntrl(s_cntrl),
        .destReg(5'd1), .memDataOut(32'h0), .writeBackData(32'h1),
        .rfWriteEnable(s_we), .rfWriteAddr(s_addr), .rfWriteData(s_data),
        .retire(s_retire), .halted(s_halted),
        .totalCount(s_total), .arithCount(s_arith), .logicCount(s_logic),
        .memCount(s_mem), .ctrlCount(s_ctrl)
    );

    // Behavioural model: the instruction currently in write-back, the halt
    // flag and unbounded counts clipped at the counter maximum.
    localparam longint MAXC = 64'hFFFF_FFFF;
    logic        m_valid, m_rw, m_m2r, m_halt;
    InstrClass   m_cls;
    logic [4:0]  m_dest;
    logic [31:0] m_mem, m_alu;
    logic        m_halted;
    longint      m_total;
    longint      m_cnt [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_m2r = 0; m_halt = 0; m_cls = ARITH;
        m_dest = 0; m_mem = 0; m_alu = 0; m_halted = 0; m_total = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge();
        bit halt_retiring;
        halt_retiring = m_valid && m_halt;
        if (m_valid) begin
            if (m_total < MAXC) m_total++;
            if (m_cnt[int'(m_cls)] < MAXC) m_cnt[int'(m_cls)]++;
        end
        if (!m_halted && !halt_retiring) begin
            m_valid = validIn; m_rw = cntrl.regWrite; m_m2r = cntrl.memToReg;
            m_halt = cntrl.halt; m_cls = cntrl.iClass; m_dest = destReg;
            m_mem = memDataOut; m_alu = writeBackData;
        end else begin
            m_valid = 0;
        end
        if (halt_retiring) m_halted = 1;
    endtask

    task automatic check_model();
        check("retire", retire, m_valid);
        check("we", rfWriteEnable, m_valid && m_rw && (m_dest != 0));
        if (m_valid) begin
            check("addr", rfWriteAddr, m_dest);
            check("data", rfWriteData, m_m2r ? m_mem : m_alu);
        end
        check("halted", halted, m_halted);
        check("total", totalCount, m_total);
        check("arith", arithCount, m_cnt[0]);
        check("logic", logicCount, m_cnt[1]);
        check("mem", memCount, m_cnt[2]);
        check("ctrl", ctrlCount, m_cnt[3]);
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic h,
                         input InstrClass c, input logic [4:0] d,
                         input logic [31:0] mem, input logic [31:0] alu);
        validIn = v;
        cntrl = '{regWrite: rw, memToReg: m2r, halt: h, iClass: c};
        destReg = d; memDataOut = mem; writeBackData = alu;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive_random();
        drive(($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'b0,
              InstrClass'($urandom_range(3)), 5'($urandom), $urandom, $urandom);
    endtask

    typedef struct {
        logic v, rw, m2r; InstrClass c; logic [4:0] d; logic [31:0] mem, alu;
        logic we; logic [4:0] addr; logic [31:0] data; logic ret;
    } vec_t;

    vec_t vt [7];

    task automatic apply_reset();
        @(posedge clk); #3;
        reset = 1; #2;
        model_reset();
        reset = 0;
    endtask

    initial begin
        logic [31:0] ctrl_snap, total_snap;

        vt[0] = '{1,1,0,ARITH,  5'd5, 32'h1234,      32'h10,        1,5'd5, 32'h10,        1};
        vt[1] = '{1,1,1,MEMACC, 5'd7, 32'hDEAD_BEEF, 32'h40,        1,5'd7, 32'hDEAD_BEEF, 1};
        vt[2] = '{1,1,0,ARITH,  5'd0, 32'h0,         32'h99,        0,5'd0, 32'h99,        1};
        vt[3] = '{0,1,0,ARITH,  5'd3, 32'h5,         32'h6,         0,5'd3, 32'h6,         0};
        vt[4] = '{1,0,0,MEMACC, 5'd9, 32'h0,         32'h100,       0,5'd9, 32'h100,       1};
        vt[5] = '{1,1,0,LOGICAL,5'd31,32'h0,         32'hFFFF_FFFF, 1,5'd31,32'hFFFF_FFFF, 1};
        vt[6] = '{1,0,0,CONTROL,5'd0, 32'h0,         32'h0,         0,5'd0, 32'h0,         1};

        reset = 1; s_validIn = 0;
        s_cntrl = '{regWrite: 1'b1, memToReg: 1'b0, halt: 1'b0, iClass: ARITH};
        drive(0, 0, 0, 0, ARITH, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_retire", retire, 0); check("rst_we", rfWriteEnable, 0);
        check("rst_addr", rfWriteAddr, 0); check("rst_data", rfWriteData, 0);
        check("rst_halted", halted, 0); check("rst_total", totalCount, 0);
        reset = 0;

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].rw, vt[i].m2r, 1'b0, vt[i].c, vt[i].d, vt[i].mem, vt[i].alu);
            step();
            check("tbl_we", rfWriteEnable, vt[i].we);
            check("tbl_ret", retire, vt[i].ret);
            if (vt[i].ret) begin
                check("tbl_addr", rfWriteAddr, vt[i].addr);
                check("tbl_data", rfWriteData, vt[i].data);
            end
        end
        drive(0, 0, 0, 0, ARITH, 0, 0, 0);
        step();
        check("tbl_arith", arithCount, 2); check("tbl_mem", memCount, 2);
        check("tbl_total", totalCount, 6);

        for (int i = 0; i < 300; i++) begin
            drive_random();
            step();
        end

        // Asynchronous reset between clock edges with counters nonzero.
        #3 reset = 1;
        #1;
        check("arst_retire", retire, 0); check("arst_we", rfWriteEnable, 0);
        check("arst_addr", rfWriteAddr, 0); check("arst_data", rfWriteData, 0);
        check("arst_total", totalCount, 0); check("arst_arith", arithCount, 0);
        check("arst_logic", logicCount, 0); check("arst_mem", memCount, 0);
        check("arst_ctrl", ctrlCount, 0); check("arst_halted", halted, 0);
        model_reset();
        #1 reset = 0;
        drive(1, 1, 0, 0, ARITH, 5'd4, 32'h0, 32'h55);
        step();
        check("post_rst_ret", retire, 1); check("post_rst_addr", rfWriteAddr, 4);
        check("post_rst_data", rfWriteData, 32'h55);

        // HALT followed immediately by ADD r2.
        drive(1, 0, 0, 1, CONTROL, 5'd0, 0, 0);
        step();
        check("halt_ret", retire, 1);
        drive(1, 1, 0, 0, ARITH, 5'd2, 0, 32'h77);
        step();
        check("halt_halted", halted, 1); check("halt_add_we", rfWriteEnable, 0);
        check("halt_add_ret", retire, 0);
        step();
        check("halt_ctrl", ctrlCount, 1); check("halt_total", totalCount, 2);
        ctrl_snap = ctrlCount; total_snap = totalCount;
        for (int i = 0; i < 12; i++) begin
            drive_random();
            step();
        end
        check("frozen_ctrl", ctrlCount, ctrl_snap);
        check("frozen_total", totalCount, total_snap);
        check("frozen_halted", halted, 1);

        // Back-to-back HALTs: only the first retires.
        apply_reset();
        drive(1, 0, 0, 1, CONTROL, 0, 0, 0);
        step();
        drive(1, 0, 0, 1, CONTROL, 0, 0, 0);
        step();
        check("b2b_ret", retire, 0);
        drive(0, 0, 0, 0, ARITH, 0, 0, 0);
        repeat (3) step();
        check("b2b_ctrl", ctrlCount, 1); check("b2b_total", totalCount, 1);

        // Four-bit counters saturate at 15 after 20 ARITH retirements.
        apply_reset();
        s_validIn = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin
                check("sat_mid_arith", s_arith, 9);
                check("sat_mid_total", s_total, 9);
            end
        end
        s_validIn = 0;
        repeat (2) @(posedge clk);
        #1;
        check("sat_arith", s_arith, 15); check("sat_total", s_total, 15);
        check("sat_ctrl", s_ctrl, 0); check("sat_halted", s_halted, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
